stat_drain: RTL and testbench

- Downstream consumer of the statistics accumulator, on the accumulator's RAM port.
- Ping-pongs the accumulator's working block (ram_blk_sel), waits for in-flight increments to retire, then scans the idle 256-word block.
- Streams each word out over a valid/ready interface and optionally zeroes it, so the next swap starts from a clean block.
- Feeds the host-side upload path.

---
 rtl/stat_drain.sv | 160 ++++++++++++++++
 tb/tb_stat_drain.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_drain.sv
// Statistics block drainer: swaps the accumulator's working block, then streams
// and optionally zeroes the idle block. Word clearing is enabled by STAT_DRAIN_CLEAR_EN.
module stat_drain #(
  parameter int unsigned PERIOD = 1000000,
  parameter int unsigned SETTLE = 16,
  parameter int unsigned CNT_W  = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        swap_req_i,
  output logic        ram_blk_sel_o,
  output logic [8:0]  ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  output logic        ram_cs_o,
  output logic        ram_we_o,
  output logic [31:0] out_data_o,
  output logic [7:0]  out_idx_o,
  output logic        out_sof_o,
  output logic        out_eof_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        overrun_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_SWAP, S_SETTLE, S_RD, S_CAP, S_PRES, S_CLR, S_NEXT, S_DONE
  } state_t;

  localparam bit               TIMER_EN = (PERIOD != 0);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD - 1);
  localparam logic [15:0]      SET_LAST = 16'((SETTLE == 0) ? 0 : SETTLE - 1);

  state_t      state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0] settle_q;
  logic [7:0]  idx_q;
  logic [31:0] data_q;
  logic        sel_q, cs_q, valid_q, sof_q, eof_q, busy_q, ovr_q;
  logic        tick, trig;
`ifdef STAT_DRAIN_CLEAR_EN
  logic        we_q;
`endif

  // Free-running period counter; held at zero when the timer is disabled.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!TIMER_EN || cnt_q == PER_LAST) cnt_d = '0;
  end

  assign tick = TIMER_EN && (cnt_q == PER_LAST);
  assign trig = swap_req_i | tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      sel_q    <= 1'b0;
      cs_q     <= 1'b0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef STAT_DRAIN_CLEAR_EN
      we_q     <= 1'b0;
`endif
    end else begin
      cs_q <= 1'b0;
`ifdef STAT_DRAIN_CLEAR_EN
      we_q <= 1'b0;
`endif
      // A trigger while busy is dropped; setting beats clearing in the same cycle.
      if (trig && state_q != S_IDLE)                  ovr_q <= 1'b1;
      else if (valid_q && out_ready_i && sof_q)       ovr_q <= 1'b0;

      case (state_q)
        S_IDLE: if (trig) begin
          state_q <= S_SWAP;
          busy_q  <= 1'b1;
        end
        S_SWAP: begin
          sel_q    <= ~sel_q;
          idx_q    <= '0;
          settle_q <= '0;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == SET_LAST) begin
            state_q <= S_RD;
            cs_q    <= 1'b1;
          end else begin
            settle_q <= settle_q + 16'd1;
          end
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          data_q  <= ram_data_i;
          valid_q <= 1'b1;
          sof_q   <= (idx_q == 8'h00);
          eof_q   <= (idx_q == 8'hFF);
          state_q <= S_PRES;
        end
        S_PRES: if (out_ready_i) begin
          valid_q <= 1'b0;
          sof_q   <= 1'b0;
          eof_q   <= 1'b0;
`ifdef STAT_DRAIN_CLEAR_EN
          cs_q    <= 1'b1;
          we_q    <= 1'b1;
          state_q <= S_CLR;
`else
          state_q <= S_NEXT;
`endif
        end
        S_CLR: state_q <= S_NEXT;
        S_NEXT: begin
          if (idx_q == 8'hFF) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 8'd1;
            cs_q    <= 1'b1;
            state_q <= S_RD;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_blk_sel_o = sel_q;
  assign ram_addr_o    = {~sel_q, idx_q};
  assign ram_data_o    = '0;
  assign ram_cs_o      = cs_q;
`ifdef STAT_DRAIN_CLEAR_EN
  assign ram_we_o      = we_q;
`else
  assign ram_we_o      = 1'b0;
`endif
  assign out_data_o    = data_q;
  assign out_idx_o     = idx_q;
  assign out_sof_o     = sof_q;
  assign out_eof_o     = eof_q;
  assign out_valid_o   = valid_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_stat_drain.sv
// Bench for stat_drain: dut_a (timer off) runs directed drains against a RAM model
// and a beat scoreboard; dut_b (PERIOD=2000) exercises the automatic swap timer.
module tb_stat_drain;

  localparam int unsigned SETTLE_N = 4;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  idx;
    logic        sof;
    logic        eof;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, swap_a, sel_a, cs_a, we_a, sof_a, eof_a, ov_a, rdy_a, busy_a, ovr_a;
  logic [8:0]  addr_a;
  logic [31:0] wdata_a, rdata_a, od_a;
  logic [7:0]  oi_a;
  logic        rst_b, swap_b, sel_b, cs_b, we_b, sof_b, eof_b, ov_b, rdy_b, busy_b, ovr_b;
  logic [8:0]  addr_b;
  logic [31:0] wdata_b, rdata_b, od_b;
  logic [7:0]  oi_b;

  stat_drain #(.PERIOD(0), .SETTLE(SETTLE_N), .CNT_W(24)) dut_a (
    .clk(clk), .rst_n(rst_a), .swap_req_i(swap_a), .ram_blk_sel_o(sel_a),
    .ram_addr_o(addr_a), .ram_data_o(wdata_a), .ram_data_i(rdata_a),
    .ram_cs_o(cs_a), .ram_we_o(we_a), .out_data_o(od_a), .out_idx_o(oi_a),
    .out_sof_o(sof_a), .out_eof_o(eof_a), .out_valid_o(ov_a),
    .out_ready_i(rdy_a), .busy_o(busy_a), .overrun_o(ovr_a));

  stat_drain #(.PERIOD(2000), .SETTLE(SETTLE_N), .CNT_W(24)) dut_b (
    .clk(clk), .rst_n(rst_b), .swap_req_i(swap_b), .ram_blk_sel_o(sel_b),
    .ram_addr_o(addr_b), .ram_data_o(wdata_b), .ram_data_i(rdata_b),
    .ram_cs_o(cs_b), .ram_we_o(we_b), .out_data_o(od_b), .out_idx_o(oi_b),
    .out_sof_o(sof_b), .out_eof_o(eof_b), .out_valid_o(ov_b),
    .out_ready_i(rdy_b), .busy_o(busy_b), .overrun_o(ovr_b));

  // RAM models
  logic [31:0] mem_a [512];
  logic [31:0] mem_b [512];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (cs_a) begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      else      rdata_a <= mem_a[addr_a];
    end
  end

  always @(posedge clk) begin
    if (cs_b) begin
      if (we_b) mem_b[addr_b] <= wdata_b;
      else      rdata_b <= mem_b[addr_b];
    end
  end

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  logic [31:0] shadow [512];
  logic  exp_sel = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // dut_a monitor: scoreboard pops on handshake, stall stability, RAM port rules
  int          beats_a = 0;
  int          stalls_a = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [7:0]  prev_i;
  logic        prev_s, prev_e;

  always @(negedge clk) begin
    if (cs_a) chk1("addr_idle_blk_a", addr_a[8], ~sel_a);
    if (cs_a && we_a) chk("clr_wdata", wdata_a, 32'h0);
`ifndef STAT_DRAIN_CLEAR_EN
    chk1("we_never", we_a, 1'b0);
`endif
    if (prev_stall) begin
      chk1("stall_valid", ov_a, 1'b1);
      chk("stall_data", od_a, prev_d);
      chk("stall_idx", {24'h0, oi_a}, {24'h0, prev_i});
      chk1("stall_sof", sof_a, prev_s);
      chk1("stall_eof", eof_a, prev_e);
    end
    if (ov_a && !rdy_a) begin
      chk1("cs_during_stall", cs_a, 1'b0);
      stalls_a <= stalls_a + 1;
    end
    if (ov_a && rdy_a) begin
      chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_data", od_a, b.d);
        chk("beat_idx", {24'h0, oi_a}, {24'h0, b.idx});
        chk1("beat_sof", sof_a, b.sof);
        chk1("beat_eof", eof_a, b.eof);
      end
      beats_a <= beats_a + 1;
    end
    prev_stall <= ov_a && !rdy_a;
    prev_d     <= od_a;
    prev_i     <= oi_a;
    prev_s     <= sof_a;
    prev_e     <= eof_a;
  end

  // dut_b monitor: swap timing relative to reset release
  int   cyc_b = 0;
  int   beats_b = 0;
  int   n_tog = 0;
  int   tog1 = -1, tog2 = -1, beats_at2 = -1;
  logic tog_sel1, tog_sel2;
  logic last_sel_b = 1'b0;

  always @(posedge clk) if (rst_b) cyc_b <= cyc_b + 1;

  always @(negedge clk) begin
    if (cs_b) chk1("addr_idle_blk_b", addr_b[8], ~sel_b);
    if (ov_b && rdy_b) beats_b <= beats_b + 1;
    if (sel_b !== last_sel_b) begin
      if (n_tog == 0) begin
        tog1 <= cyc_b; tog_sel1 <= sel_b;
      end else if (n_tog == 1) begin
        tog2 <= cyc_b; tog_sel2 <= sel_b; beats_at2 <= beats_b;
      end
      n_tog <= n_tog + 1;
    end
    last_sel_b <= sel_b;
  end

  task automatic preload(input logic blk, input int base);
    for (int i = 0; i < 256; i++) begin
      pl_en   = 1'b1;
      pl_addr = {blk, 8'(i)};
      pl_data = 32'(base + i);
      shadow[{blk, 8'(i)}] = 32'(base + i);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  // The block read is ~new_sel, i.e. the select value before the swap.
  task automatic run_drain(input bit rnd, input int ovr_at, input int rst_at);
    logic blk;
    bit   seen;
    int   n;
    int   b0;
    blk  = exp_sel;
    seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      beat_t b;
      b.d   = shadow[{blk, 8'(i)}];
      b.idx = 8'(i);
      b.sof = (i == 0);
      b.eof = (i == 255);
      exp_q.push_back(b);
    end
`ifdef STAT_DRAIN_CLEAR_EN
    for (int i = 0; i < 256; i++) shadow[{blk, 8'(i)}] = 32'h0;
`endif
    exp_sel = ~exp_sel;
    b0 = beats_a;
    swap_a = 1'b1;
    @(posedge clk); #1;
    swap_a = 1'b0;
    chk1("busy_after_req", busy_a, 1'b1);
    n = 0;
    while (busy_a && n < 20000) begin
      rdy_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ovr_at >= 0 && ov_a && oi_a == 8'(ovr_at) && !seen) begin
        swap_a = 1'b1;
        seen = 1'b1;
      end
      if (rst_at >= 0 && ov_a && oi_a == 8'(rst_at)) begin
        rst_a = 1'b0;
        break;
      end
      @(posedge clk); #1;
      swap_a = 1'b0;
      n++;
    end
    rdy_a = 1'b1;
    if (rst_at < 0) begin
      chk1("drain_finished", busy_a, 1'b0);
      @(negedge clk); #1;
      chk("beat_count", 32'(beats_a - b0), 32'd256);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; swap_a = 1'b0; swap_b = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 512; i++) mem_b[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_sel", sel_a, 1'b0);
    chk1("rst_cs", cs_a, 1'b0);
    chk1("rst_we", we_a, 1'b0);
    chk1("rst_valid", ov_a, 1'b0);
    chk1("rst_sof", sof_a, 1'b0);
    chk1("rst_eof", eof_a, 1'b0);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_overrun", ovr_a, 1'b0);
    chk("rst_data", od_a, 32'h0);
    chk("rst_idx", {24'h0, oi_a}, 32'h0);
    rst_a = 1'b1; rst_b = 1'b1;

    preload(1'b0, 1);
    preload(1'b1, 1000);

    // Drain 1: full-rate, data 1..256
    run_drain(1'b0, -1, -1);
    chk1("sel_after_drain1", sel_a, 1'b1);
`ifdef STAT_DRAIN_CLEAR_EN
    for (int i = 0; i < 256; i++) chk("cleared_blk0", mem_a[i], 32'h0);
`endif

    // Drain 2: random back-pressure
    run_drain(1'b1, -1, -1);
    chk1("sel_after_drain2", sel_a, 1'b0);
    chk1("stalls_seen", stalls_a > 0, 1'b1);

    // Drain 3: same block as drain 1, no new stats; swap request during PRES idx 10
    run_drain(1'b0, 10, -1);
    chk1("overrun_set", ovr_a, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk1("no_extra_swap_busy", busy_a, 1'b0);
    chk1("no_extra_swap_sel", sel_a, 1'b1);

    // Drain 4: overrun clears on the SOF handshake
    preload(1'b1, 5000);
    chk1("overrun_sticky", ovr_a, 1'b1);
    run_drain(1'b0, -1, -1);
    chk1("overrun_cleared", ovr_a, 1'b0);

    // Drain 5: reset in PRES at idx 100
    preload(1'b0, 9000);
    run_drain(1'b0, -1, 100);
    #1;
    exp_q.delete();
    chk1("mrst_sel", sel_a, 1'b0);
    chk1("mrst_cs", cs_a, 1'b0);
    chk1("mrst_valid", ov_a, 1'b0);
    chk1("mrst_busy", busy_a, 1'b0);
    chk("mrst_data", od_a, 32'h0);
    chk("mrst_idx", {24'h0, oi_a}, 32'h0);
    @(posedge clk); #1;
    for (int i = 100; i < 256; i++) chk("untouched_after_rst", mem_a[i], 32'(9000 + i));
    rst_a = 1'b1;

    // Timer-driven swaps on dut_b
    while (n_tog < 2 && cyc_b < 6000) @(posedge clk);
    #1;
    chk("timer_swap1_cycle", 32'(tog1), 32'd2001);
    chk("timer_swap2_cycle", 32'(tog2), 32'd4001);
    chk1("timer_sel1", tog_sel1, 1'b1);
    chk1("timer_sel2", tog_sel2, 1'b0);
    chk("timer_drain1_beats", 32'(beats_at2), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
